program_loader: RTL and testbench

- Sits directly upstream of the CPU top level.
- Receives a byte stream over a valid/ready handshake, validates a framed program image, and writes it into instruction memory as 16-bit half-words. It drives the CPU's program_mem_write_en_i, instruction_i and instruction_addr_i inputs.
- Holds the CPU in reset until a complete, checksum-correct image has been written.

---
 rtl/program_loader_if.sv | 20 ++
 rtl/program_loader.sv | 185 ++++++++++++++++++
 tb/tb_program_loader.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/program_loader_if.sv
// Byte-stream handshake and instruction-memory write bus of the program loader.
// slave = loader side, master = byte source / memory side.
interface program_loader_if;
  logic        byte_valid_i;
  logic [7:0]  byte_i;
  logic        byte_ready_o;
  logic        program_mem_write_en_o;
  logic [15:0] instruction_o;
  logic [31:0] instruction_addr_o;

  modport slave (
    input  byte_valid_i, byte_i,
    output byte_ready_o, program_mem_write_en_o, instruction_o, instruction_addr_o
  );

  modport master (
    output byte_valid_i, byte_i,
    input  byte_ready_o, program_mem_write_en_o, instruction_o, instruction_addr_o
  );
endinterface

// File: rtl/program_loader.sv
// Framed program-image loader: A5, len_lo, len_hi, N half-words, XOR checksum.
// Optional inter-byte timeout enabled by defining LOADER_TIMEOUT_EN.
module program_loader #(
  parameter logic [31:0] BASE_ADDR      = 32'd0,
  parameter int unsigned MAX_HALF_WORDS = 1024,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic                clk_i,
  input  logic                reset_i,
  program_loader_if.slave     bus,
  input  logic                start_i,
  output logic                cpu_reset_o,
  output logic                done_o,
  output logic                error_o,
  output logic [1:0]          error_code_o,
  output logic [15:0]         words_loaded_o
);
  typedef enum logic [3:0] {
    IDLE, LEN_LO, LEN_HI, DATA_LO, DATA_HI, WRITE, CHECKSUM, DONE, ERROR
  } state_e;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  state_e      state_q, state_d;
  logic [7:0]  len_lo_q, len_lo_d;
  logic [15:0] len_q, len_d;
  logic [7:0]  lo_q, lo_d;
  logic [7:0]  xor_q, xor_d;
  logic [15:0] words_q, words_d;
  logic        we_q, we_d;
  logic [15:0] instr_q, instr_d;
  logic [31:0] addr_q, addr_d;
  logic        cpu_rst_q, cpu_rst_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [1:0]  code_q, code_d;

  logic        ready, accept, tmo_hit;
  logic [15:0] len_w;

  assign ready  = !(state_q inside {WRITE, DONE, ERROR});
  assign accept = bus.byte_valid_i && ready;
  assign len_w  = {bus.byte_i, len_lo_q};

`ifdef LOADER_TIMEOUT_EN
  logic [31:0] tmo_q, tmo_d;
  logic        tmo_run;

  // Counts idle cycles between bytes; WRITE is the loader's own stall and is excluded.
  assign tmo_run = state_q inside {LEN_LO, LEN_HI, DATA_LO, DATA_HI, CHECKSUM};
  assign tmo_hit = tmo_run && !accept && (tmo_q == 32'(TIMEOUT_CYCLES - 1));
  assign tmo_d   = (!tmo_run || accept) ? 32'd0 : tmo_q + 32'd1;

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) tmo_q <= 32'd0;
    else          tmo_q <= tmo_d;
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    len_lo_d = len_lo_q;
    len_d    = len_q;
    lo_d     = lo_q;
    xor_d    = xor_q;
    words_d  = words_q;
    we_d     = 1'b0;
    instr_d  = instr_q;
    addr_d   = addr_q;
    cpu_rst_d = cpu_rst_q;
    done_d   = done_q;
    err_d    = err_q;
    code_d   = code_q;

    unique case (state_q)
      IDLE: if (accept && bus.byte_i == SYNC_BYTE) begin
        state_d = LEN_LO;
        xor_d   = 8'd0;
        words_d = 16'd0;
      end
      LEN_LO: if (accept) begin
        len_lo_d = bus.byte_i;
        xor_d    = xor_q ^ bus.byte_i;
        state_d  = LEN_HI;
      end
      LEN_HI: if (accept) begin
        len_d = len_w;
        xor_d = xor_q ^ bus.byte_i;
        if (len_w == 16'd0 || {16'd0, len_w} > 32'(MAX_HALF_WORDS)) begin
          state_d = ERROR;
          err_d   = 1'b1;
          code_d  = 2'd1;
        end else begin
          state_d = DATA_LO;
        end
      end
      DATA_LO: if (accept) begin
        lo_d    = bus.byte_i;
        xor_d   = xor_q ^ bus.byte_i;
        state_d = DATA_HI;
      end
      DATA_HI: if (accept) begin
        // Strobe, data and address are registered here so they appear together in WRITE.
        xor_d   = xor_q ^ bus.byte_i;
        we_d    = 1'b1;
        instr_d = {bus.byte_i, lo_q};
        addr_d  = BASE_ADDR + {15'd0, words_q, 1'b0};
        state_d = WRITE;
      end
      WRITE: begin
        words_d = words_q + 16'd1;
        state_d = (words_q + 16'd1 == len_q) ? CHECKSUM : DATA_LO;
      end
      CHECKSUM: if (accept) begin
        if (bus.byte_i == xor_q) begin
          state_d   = DONE;
          done_d    = 1'b1;
          cpu_rst_d = 1'b0;
        end else begin
          state_d = ERROR;
          err_d   = 1'b1;
          code_d  = 2'd2;
        end
      end
      DONE, ERROR: if (start_i) begin
        state_d   = IDLE;
        cpu_rst_d = 1'b1;
        done_d    = 1'b0;
        err_d     = 1'b0;
        code_d    = 2'd0;
      end
      default: state_d = IDLE;
    endcase

    if (tmo_hit) begin
      state_d = ERROR;
      err_d   = 1'b1;
      code_d  = 2'd3;
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q   <= IDLE;
      len_lo_q  <= 8'd0;
      len_q     <= 16'd0;
      lo_q      <= 8'd0;
      xor_q     <= 8'd0;
      words_q   <= 16'd0;
      we_q      <= 1'b0;
      instr_q   <= 16'd0;
      addr_q    <= BASE_ADDR;
      cpu_rst_q <= 1'b1;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      code_q    <= 2'd0;
    end else begin
      state_q   <= state_d;
      len_lo_q  <= len_lo_d;
      len_q     <= len_d;
      lo_q      <= lo_d;
      xor_q     <= xor_d;
      words_q   <= words_d;
      we_q      <= we_d;
      instr_q   <= instr_d;
      addr_q    <= addr_d;
      cpu_rst_q <= cpu_rst_d;
      done_q    <= done_d;
      err_q     <= err_d;
      code_q    <= code_d;
    end
  end

  assign bus.byte_ready_o           = ready;
  assign bus.program_mem_write_en_o = we_q;
  assign bus.instruction_o          = instr_q;
  assign bus.instruction_addr_o     = addr_q;
  assign cpu_reset_o                = cpu_rst_q;
  assign done_o                     = done_q;
  assign error_o                    = err_q;
  assign error_code_o               = code_q;
  assign words_loaded_o             = words_q;
endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: table vectors, hand-timed sequences and random frames
// checked against a stream-parsing reference model.
module tb_program_loader;
  localparam logic [31:0] BASEA = 32'hFFFF_FFFA;
  localparam int          MAXW  = 8;

  typedef struct packed { logic [31:0] a; logic [15:0] d; } wr_t;
  typedef struct {
    logic [191:0] b;
    int           n;
    bit           gaps;
    bit           exp_done;
    logic [1:0]   exp_code;
    logic [15:0]  exp_words;
  } vec_t;

  logic clk_i = 1'b0;
  logic reset_i = 1'b0;
  logic start_i = 1'b0;
  logic cpu_reset_o, done_o, error_o;
  logic [1:0]  error_code_o;
  logic [15:0] words_loaded_o;

  program_loader_if bus();

  program_loader #(.BASE_ADDR(BASEA), .MAX_HALF_WORDS(MAXW), .TIMEOUT_CYCLES(16)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .bus(bus), .start_i(start_i),
    .cpu_reset_o(cpu_reset_o), .done_o(done_o), .error_o(error_o),
    .error_code_o(error_code_o), .words_loaded_o(words_loaded_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int failures = 0;
  wr_t act_wr[$];
  wr_t exp_wr[$];
  logic [7:0] stim_q[$];
  bit m_done;
  logic [1:0] m_code;
  logic [15:0] m_words;
  vec_t vt[7];

  always @(negedge clk_i)
    if (bus.program_mem_write_en_o)
      act_wr.push_back('{a: bus.instruction_addr_o, d: bus.instruction_o});

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Reference: parse the stream as a frame and derive writes and final status.
  task automatic model();
    int i, n;
    logic [7:0] x;
    exp_wr.delete();
    m_done = 1'b0; m_code = 2'd0; m_words = 16'd0;
    i = 0;
    while (i < stim_q.size() && stim_q[i] != 8'hA5) i++;
    if (i + 2 >= stim_q.size()) return;
    n = int'({stim_q[i+2], stim_q[i+1]});
    if (n == 0 || n > MAXW) begin m_code = 2'd1; return; end
    x = stim_q[i+1] ^ stim_q[i+2];
    for (int k = 0; k < n; k++) begin
      exp_wr.push_back('{a: BASEA + 32'(2 * k), d: {stim_q[i+4+2*k], stim_q[i+3+2*k]}});
      x = x ^ stim_q[i+3+2*k] ^ stim_q[i+4+2*k];
    end
    m_words = 16'(n);
    if (stim_q[i+3+2*n] == x) m_done = 1'b1;
    else m_code = 2'd2;
  endtask

  // Entered and left at posedge+1; returns right after the accepting edge.
  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int guard = 0;
    if (gaps) repeat ($urandom_range(0, 3)) begin @(posedge clk_i); #1; end
    bus.byte_valid_i = 1'b1;
    bus.byte_i = b;
    @(negedge clk_i);
    while (!bus.byte_ready_o && guard < 100) begin @(negedge clk_i); guard++; end
    if (guard >= 100) begin
      checks++; failures++;
      $display("FAIL send_wait actual=not_ready required=ready byte=%0h", b);
    end
    @(posedge clk_i); #1;
    bus.byte_valid_i = 1'b0;
  endtask

  task automatic run_stream(input bit gaps);
    model();
    act_wr.delete();
    foreach (stim_q[i]) send_byte(stim_q[i], gaps);
  endtask

  task automatic finish_frame(input bit ed, input logic [1:0] ec, input logic [15:0] ew);
    repeat (2) @(posedge clk_i);
    #1;
    check("done", done_o, ed);
    check("error", error_o, ec != 2'd0);
    check("error_code", error_code_o, ec);
    check("cpu_reset", cpu_reset_o, !ed);
    check("words", words_loaded_o, ew);
    check("ready_final", bus.byte_ready_o, 1'b0);
    check("wr_count", act_wr.size(), exp_wr.size());
    for (int k = 0; k < exp_wr.size() && k < act_wr.size(); k++)
      check("wr_entry", act_wr[k], exp_wr[k]);
  endtask

  task automatic rearm();
    start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    check("rearm_cpu_reset", cpu_reset_o, 1'b1);
    check("rearm_done", done_o, 1'b0);
    check("rearm_error", error_o, 1'b0);
    check("rearm_code", error_code_o, 2'd0);
    check("rearm_ready", bus.byte_ready_o, 1'b1);
  endtask

  task automatic load_vec(input int idx);
    stim_q.delete();
    for (int i = 0; i < vt[idx].n; i++)
      stim_q.push_back(vt[idx].b[8*(vt[idx].n-1-i) +: 8]);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_we"}, bus.program_mem_write_en_o, 1'b0);
    check({tag, "_instr"}, bus.instruction_o, 16'd0);
    check({tag, "_addr"}, bus.instruction_addr_o, BASEA);
    check({tag, "_cpu_reset"}, cpu_reset_o, 1'b1);
    check({tag, "_done"}, done_o, 1'b0);
    check({tag, "_error"}, error_o, 1'b0);
    check({tag, "_code"}, error_code_o, 2'd0);
    check({tag, "_words"}, words_loaded_o, 16'd0);
    check({tag, "_ready"}, bus.byte_ready_o, 1'b1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  x, b;
    logic [15:0] nn;
    int r;

    vt[0] = '{b: 192'({8'hA5, 8'h02, 8'h00, 8'h34, 8'h12, 8'h78, 8'h56, 8'h0A}), n: 8,
              gaps: 1'b0, exp_done: 1'b1, exp_code: 2'd0, exp_words: 16'd2};
    vt[1] = '{b: 192'({8'hA5, 8'h02, 8'h00, 8'h34, 8'h12, 8'h78, 8'h56, 8'h0B}), n: 8,
              gaps: 1'b0, exp_done: 1'b0, exp_code: 2'd2, exp_words: 16'd2};
    vt[2] = '{b: 192'({8'hA5, 8'h00, 8'h00}), n: 3,
              gaps: 1'b0, exp_done: 1'b0, exp_code: 2'd1, exp_words: 16'd0};
    vt[3] = '{b: 192'({8'hA5, 8'h09, 8'h00}), n: 3,
              gaps: 1'b0, exp_done: 1'b0, exp_code: 2'd1, exp_words: 16'd0};
    vt[4] = '{b: 192'({8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h01, 8'h00, 8'hCD, 8'hAB, 8'h67}), n: 9,
              gaps: 1'b1, exp_done: 1'b1, exp_code: 2'd0, exp_words: 16'd1};
    vt[5] = '{b: 192'({8'hA5, 8'h04, 8'h00, 8'h11, 8'h11, 8'h22, 8'h22, 8'h33, 8'h33,
                       8'h44, 8'h44, 8'h04}), n: 12,
              gaps: 1'b1, exp_done: 1'b1, exp_code: 2'd0, exp_words: 16'd4};
    vt[6] = '{b: 192'({8'hA5, 8'h00, 8'h01}), n: 3,
              gaps: 1'b0, exp_done: 1'b0, exp_code: 2'd1, exp_words: 16'd0};

    bus.byte_valid_i = 1'b0;
    bus.byte_i = 8'h00;
    #12;
    check_reset_values("reset");
    @(posedge clk_i); #1;
    reset_i = 1'b1;

    // Table vectors
    for (int v = 0; v < 7; v++) begin
      load_vec(v);
      run_stream(vt[v].gaps);
      finish_frame(vt[v].exp_done, vt[v].exp_code, vt[v].exp_words);
      rearm();
    end

    // Write latency, WRITE back-pressure and cpu_reset release timing
    act_wr.delete();
    send_byte(8'hA5, 0); send_byte(8'h02, 0); send_byte(8'h00, 0); send_byte(8'h34, 0);
    send_byte(8'h12, 0);
    check("lat_we", bus.program_mem_write_en_o, 1'b1);
    check("lat_instr", bus.instruction_o, 16'h1234);
    check("lat_addr", bus.instruction_addr_o, BASEA);
    check("write_ready", bus.byte_ready_o, 1'b0);
    bus.byte_valid_i = 1'b1;
    bus.byte_i = 8'h78;
    @(posedge clk_i); #1;
    check("write_strobe_one_cycle", bus.program_mem_write_en_o, 1'b0);
    check("words_after_write", words_loaded_o, 16'd1);
    send_byte(8'h78, 0);
    send_byte(8'h56, 0);
    check("lat2_instr", bus.instruction_o, 16'h5678);
    check("lat2_addr", bus.instruction_addr_o, BASEA + 32'd2);
    check("cpu_reset_before_cks", cpu_reset_o, 1'b1);
    send_byte(8'h0A, 0);
    check("cpu_reset_after_cks", cpu_reset_o, 1'b0);
    check("done_after_cks", done_o, 1'b1);
    rearm();

    // Asynchronous reset mid-load, then a full frame from BASE_ADDR
    send_byte(8'hA5, 0); send_byte(8'h04, 0); send_byte(8'h00, 0);
    send_byte(8'h11, 0); send_byte(8'h11, 0);
    repeat (2) @(posedge clk_i);
    #3 reset_i = 1'b0;
    #1 check_reset_values("midreset");
    @(posedge clk_i); #1;
    reset_i = 1'b1;
    load_vec(5);
    run_stream(1'b0);
    finish_frame(1'b1, 2'd0, 16'd4);
    rearm();

`ifdef LOADER_TIMEOUT_EN
    act_wr.delete();
    send_byte(8'hA5, 0); send_byte(8'h01, 0); send_byte(8'h00, 0);
    repeat (15) @(posedge clk_i);
    #1 check("tmo_not_yet", error_o, 1'b0);
    @(posedge clk_i); #1;
    check("tmo_error", error_o, 1'b1);
    check("tmo_code", error_code_o, 2'd3);
    check("tmo_cpu_reset", cpu_reset_o, 1'b1);
    rearm();
    send_byte(8'hA5, 0); send_byte(8'h01, 0); send_byte(8'h00, 0);
    repeat (15) @(posedge clk_i);
    #1;
    send_byte(8'hCD, 0); send_byte(8'hAB, 0); send_byte(8'h67, 0);
    check("stall15_done", done_o, 1'b1);
    check("stall15_error", error_o, 1'b0);
    rearm();
`else
    send_byte(8'hA5, 0); send_byte(8'h01, 0); send_byte(8'h00, 0);
    repeat (40) @(posedge clk_i);
    #1;
    send_byte(8'hCD, 0); send_byte(8'hAB, 0); send_byte(8'h67, 0);
    check("long_stall_done", done_o, 1'b1);
    check("long_stall_error", error_o, 1'b0);
    rearm();
`endif

    // Random frames: garbage prefix, random lengths, occasional bad checksum, random gaps
    for (int t = 0; t < 24; t++) begin
      stim_q.delete();
      repeat ($urandom_range(0, 3)) begin
        b = 8'($urandom);
        if (b == 8'hA5) b = 8'h00;
        stim_q.push_back(b);
      end
      stim_q.push_back(8'hA5);
      r = $urandom_range(0, 9);
      if (r == 0)      nn = 16'd0;
      else if (r == 1) nn = 16'(MAXW + 1 + $urandom_range(0, 300));
      else             nn = 16'($urandom_range(1, MAXW));
      stim_q.push_back(nn[7:0]);
      stim_q.push_back(nn[15:8]);
      if (nn >= 16'd1 && nn <= 16'(MAXW)) begin
        x = nn[7:0] ^ nn[15:8];
        for (int k = 0; k < 2 * int'(nn); k++) begin
          b = 8'($urandom);
          stim_q.push_back(b);
          x = x ^ b;
        end
        if ($urandom_range(0, 3) == 0) x = x ^ 8'(1 << $urandom_range(0, 7));
        stim_q.push_back(x);
      end
      run_stream(1'($urandom_range(0, 1)));
      finish_frame(m_done, m_code, m_words);
      rearm();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
